mem_port_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch (IFU) and load/store (LSU) requesters in the npc core.
- Replaces the direct pc/waddr wiring into memory once fetch and data access become multi-cycle.
- Allows one outstanding transaction, with fixed LSU priority, an IFU anti-starvation streak limit, and a response timeout.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between IFU and LSU, one transaction in flight, LSU priority with IFU streak guard.
// Latency: accept -> mem_req_valid next cycle; mem_resp_valid (or timeout) -> owner resp pulse next cycle.
// Backpressure: requester ready only while idle; downstream request held stable until mem_req_ready.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int MASK_WIDTH     = 8,
  parameter int LSU_STREAK_MAX = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_resp_err,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_resp_err,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  spurious_resp
);

  // Streak counter must hold 0..LSU_STREAK_MAX; the +2 keeps it at least one bit wide.
  localparam int STREAK_W = $clog2(LSU_STREAK_MAX + 2);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(LSU_STREAK_MAX);
  // The wait counter starts at 0 on entering WAIT, so the last waiting cycle holds TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]          state;
  logic                ownerLsu;
  logic [STREAK_W-1:0] streak;
  logic [7:0]          waitCnt;
  logic                grantIfu;
  logic                grantLsu;
  logic                waitDone;
  logic                timedOut;

  // Grant selection: only in IDLE; LSU wins ties unless IFU has been passed over LSU_STREAK_MAX times.
  always_comb begin
    grantIfu = 1'b0;
    grantLsu = 1'b0;
    if (state == IDLE) begin
      if (lsu_req_valid && !(ifu_req_valid && (streak == STREAK_LIMIT))) begin
        grantLsu = 1'b1;
      end else if (ifu_req_valid) begin
        grantIfu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grantIfu;
  assign lsu_req_ready = grantLsu;

  // A real response on the final waiting cycle beats the timeout.
  assign waitDone = (state == WAIT) && (mem_resp_valid || (waitCnt == WAIT_LAST));
  assign timedOut = (state == WAIT) && !mem_resp_valid && (waitCnt == WAIT_LAST);

  // Transaction sequencing: latch the granted request, hold it downstream, count the wait for a reply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      ownerLsu      <= 1'b0;
      streak        <= '0;
      waitCnt       <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantLsu) begin
            state         <= REQ;
            ownerLsu      <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            // Only grants that actually made IFU wait count toward the streak.
            if (!ifu_req_valid) begin
              streak <= '0;
            end else if (streak != STREAK_LIMIT) begin
              streak <= streak + 1'b1;
            end
          end else if (grantIfu) begin
            state         <= REQ;
            ownerLsu      <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            streak        <= '0;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            waitCnt       <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (waitDone) begin
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response delivery: one-cycle pulse to the owner only; data is loaded only from a real reply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= waitDone && !ownerLsu;
      ifu_resp_err   <= timedOut && !ownerLsu;
      lsu_resp_valid <= waitDone && ownerLsu;
      lsu_resp_err   <= timedOut && ownerLsu;
      if ((state == WAIT) && mem_resp_valid) begin
        if (ownerLsu) begin
          lsu_rdata <= mem_rdata;
        end else begin
          ifu_rdata <= mem_rdata;
        end
      end
    end
  end

  // Sticky flag for a downstream reply that arrived when nothing was waiting for it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spurious_resp <= 1'b0;
    end else if (mem_resp_valid && (state != WAIT)) begin
      spurious_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized + directed bench for mem_port_arbiter with a transaction-level reference model.
// Latency: model predicts request one cycle after accept and response one cycle after reply/timeout.
// Backpressure: memory agent applies random or scripted mem_req_ready stalls.
module tb_mem_port_arbiter;

  localparam int TMO  = 255;
  localparam int SMAX = 4;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, spurious_resp;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .spurious_resp(spurious_resp)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus queues and agent knobs
  req_t        ifuQ[$];
  req_t        lsuQ[$];
  int          gapPct = 0;
  bit          randReady = 0;
  bit          randTimeouts = 0;
  bit          forceNoResp = 0;
  int          fixDelay = 0;
  bit          fixDataEn = 0;
  logic [63:0] fixData = '0;
  int          bpLeft = 0;
  bit          strayReq = 0;

  // Reference model state
  int          k = 0;
  bit          haveCur = 0, issued = 0, gotResp = 0, curLsu = 0, mSpur = 0, resetPrev = 0;
  req_t        cur;
  int          acceptN = 0, hsN = 0, respDueN = 0, lsuRun = 0;
  logic [63:0] respData = '0, mIfuData = '0, mLsuData = '0;
  logic        respErr = 1'b0;
  int          accCnt = 0, hsCnt = 0, lastRespN = 0, lastHsN = 0, lastReqCycles = 0;
  logic        lastRespErr = 1'b0;
  int          grantLog[$];

  function automatic req_t mkReq(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, k);
    end
  endtask

  // Monitor + scoreboard: predicts every DUT output each cycle from the transaction model
  always @(negedge clk) begin : monitor
    bit expI, expL, expMem, gI, gL;
    k++;
    if (resetPrev) begin
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_wen", 64'(mem_wen), 64'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_mem_wmask", 64'(mem_wmask), 64'h0);
      chk("rst_ifu_err", 64'(ifu_resp_err), 64'h0);
      chk("rst_lsu_err", 64'(lsu_resp_err), 64'h0);
    end
    chk("spurious_resp", 64'(spurious_resp), 64'(mSpur));

    expI = 0; expL = 0;
    if (haveCur && issued && respDueN == k) begin
      if (curLsu) expL = 1; else expI = 1;
      if (!respErr) begin
        if (curLsu) mLsuData = respData; else mIfuData = respData;
      end
    end
    chk("ifu_resp_valid", 64'(ifu_resp_valid), 64'(expI));
    chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(expL));
    if (expI) chk("ifu_resp_err", 64'(ifu_resp_err), 64'(respErr));
    if (expL) chk("lsu_resp_err", 64'(lsu_resp_err), 64'(respErr));
    chk("ifu_rdata", ifu_rdata, mIfuData);
    chk("lsu_rdata", lsu_rdata, mLsuData);
    if (expI || expL) haveCur = 0;
    if (ifu_resp_valid || lsu_resp_valid) begin
      lastRespN = k;
      lastRespErr = ifu_resp_err | lsu_resp_err;
    end

    expMem = haveCur && !issued;
    chk("mem_req_valid", 64'(mem_req_valid), 64'(expMem));
    if (expMem) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wen", 64'(mem_wen), 64'(cur.wen));
      chk("mem_wdata", mem_wdata, cur.wdata);
      chk("mem_wmask", 64'(mem_wmask), 64'(cur.wmask));
    end
    if (mem_req_valid && mem_req_ready) begin
      hsCnt++;
      lastHsN = k;
      lastReqCycles = k - acceptN;
    end
    if (expMem && mem_req_ready) begin
      issued = 1; gotResp = 0; hsN = k;
      respDueN = k + 1 + TMO;   // timeout unless a reply shows up
      respErr = 1'b1;
    end
    if (mem_resp_valid) begin
      if (haveCur && issued && !gotResp && k > hsN && k <= hsN + TMO) begin
        gotResp = 1; respDueN = k + 1; respData = mem_rdata; respErr = 1'b0;
      end else begin
        mSpur = 1;
      end
    end

    gI = 0; gL = 0;
    if (!haveCur) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (lsuRun == SMAX) gI = 1; else gL = 1;
      end else if (ifu_req_valid) gI = 1;
      else if (lsu_req_valid) gL = 1;
    end
    chk("ifu_req_ready", 64'(ifu_req_ready), 64'(gI));
    chk("lsu_req_ready", 64'(lsu_req_ready), 64'(gL));
    if (ifu_req_valid && ifu_req_ready) begin grantLog.push_back(0); accCnt++; end
    if (lsu_req_valid && lsu_req_ready) begin grantLog.push_back(1); accCnt++; end
    if (gL) begin
      cur = mkReq(lsu_addr, lsu_wen, lsu_wdata, lsu_wmask);
      curLsu = 1;
      lsuRun = ifu_req_valid ? ((lsuRun < SMAX) ? lsuRun + 1 : SMAX) : 0;
    end
    if (gI) begin
      cur = mkReq(ifu_addr, 1'b0, 64'h0, 8'h0);
      curLsu = 0;
      lsuRun = 0;
    end
    if (gI || gL) begin haveCur = 1; issued = 0; acceptN = k; end

    resetPrev = !rst;
    if (!rst) begin
      haveCur = 0; lsuRun = 0; mIfuData = '0; mLsuData = '0; mSpur = 0;
    end
  end

  // Requester agents: hold valid and payload until accepted, scramble payload while idle
  initial begin : reqDriver
    bit ia, la;
    req_t dummy;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    forever begin
      @(negedge clk);
      ia = ifu_req_valid && ifu_req_ready;
      la = lsu_req_valid && lsu_req_ready;
      @(posedge clk); #1;
      if (ia) dummy = ifuQ.pop_front();
      if (la) dummy = lsuQ.pop_front();
      if (ifuQ.size() != 0 && ((ifu_req_valid && !ia) || $urandom_range(99) >= gapPct)) begin
        ifu_req_valid = 1; ifu_addr = ifuQ[0].addr;
      end else begin
        ifu_req_valid = 0; ifu_addr = {$urandom, $urandom};
      end
      if (lsuQ.size() != 0 && ((lsu_req_valid && !la) || $urandom_range(99) >= gapPct)) begin
        lsu_req_valid = 1; lsu_addr = lsuQ[0].addr; lsu_wen = lsuQ[0].wen;
        lsu_wdata = lsuQ[0].wdata; lsu_wmask = lsuQ[0].wmask;
      end else begin
        lsu_req_valid = 0; lsu_addr = {$urandom, $urandom}; lsu_wen = 1'($urandom);
        lsu_wdata = {$urandom, $urandom}; lsu_wmask = 8'($urandom);
      end
    end
  end

  // Memory agent: request stalls, reply delay, timeouts and stray replies
  initial begin : memAgent
    bit hs;
    int respCnt;
    respCnt = -1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (forceNoResp || (randTimeouts && $urandom_range(15) == 0)) respCnt = -1;
        else if (!randTimeouts) respCnt = fixDelay;
        else if ($urandom_range(15) == 0) respCnt = TMO - 1;
        else respCnt = $urandom_range(4);
      end
      mem_rdata = {$urandom, $urandom};
      mem_resp_valid = 0;
      if (respCnt == 0) begin
        mem_resp_valid = 1;
        if (fixDataEn) mem_rdata = fixData;
        respCnt = -1;
      end else if (respCnt > 0) begin
        respCnt--;
      end
      if (strayReq) begin mem_resp_valid = 1; strayReq = 0; end
      if (bpLeft > 0 && mem_req_valid) begin
        mem_req_ready = 0; bpLeft--;
      end else if (randReady) begin
        mem_req_ready = ($urandom_range(3) != 0);
      end else begin
        mem_req_ready = 1;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic drain(input string name, input int maxCyc);
    int n = 0;
    while ((ifuQ.size() != 0 || lsuQ.size() != 0 || haveCur) && n < maxCyc) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= maxCyc) begin
      errors++;
      $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
    end
    waitCycles(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, hs0, guard;
    int starve[7];
    starve = '{1, 1, 1, 1, 0, 1, 1};
    rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    waitCycles(2);

    // IFU-only fetch
    fixDataEn = 1; fixData = 64'h0000_0413; fixDelay = 1;
    base = grantLog.size();
    ifuQ.push_back(mkReq(64'h8000_0000, 1'b0, 64'h0, 8'h0));
    drain("fetch", 100);
    chk("fetch_req_latency", 64'(lastReqCycles), 64'd1);
    chk("fetch_rdata", ifu_rdata, 64'h0000_0413);
    chk("fetch_grants", 64'(grantLog.size() - base), 64'd1);
    fixDataEn = 0; fixDelay = 0;

    // Simultaneous requests: LSU store first, then IFU
    base = grantLog.size();
    ifuQ.push_back(mkReq(64'h8000_0004, 1'b0, 64'h0, 8'h0));
    lsuQ.push_back(mkReq(64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F));
    drain("simul", 100);
    chk("simul_first_lsu", 64'(grantLog[base]), 64'd1);
    chk("simul_second_ifu", 64'(grantLog[base+1]), 64'd0);

    // Starvation guard
    base = grantLog.size();
    ifuQ.push_back(mkReq(64'h8000_0008, 1'b0, 64'h0, 8'h0));
    for (int i = 0; i < 6; i++) lsuQ.push_back(mkReq(64'h8000_2000 + 64'(8 * i), 1'b0, 64'h0, 8'h0));
    drain("starve", 200);
    chk("starve_count", 64'(grantLog.size() - base), 64'd7);
    for (int i = 0; i < 7; i++) chk($sformatf("starve_order%0d", i), 64'(grantLog[base+i]), 64'(starve[i]));

    // Downstream backpressure
    hs0 = hsCnt;
    bpLeft = 5;
    lsuQ.push_back(mkReq(64'h8000_3000, 1'b0, 64'h0, 8'h0));
    drain("bp", 100);
    chk("bp_req_cycles", 64'(lastReqCycles), 64'd6);
    chk("bp_handshakes", 64'(hsCnt - hs0), 64'd1);

    // Timeout, then stray reply, then normal request
    forceNoResp = 1;
    lsuQ.push_back(mkReq(64'h8000_4000, 1'b0, 64'h0, 8'h0));
    drain("timeout", 400);
    chk("timeout_err", 64'(lastRespErr), 64'd1);
    chk("timeout_latency", 64'(lastRespN - lastHsN - 1), 64'(TMO));
    forceNoResp = 0;
    strayReq = 1;
    waitCycles(3);
    chk("stray_spurious", 64'(spurious_resp), 64'd1);
    ifuQ.push_back(mkReq(64'h8000_0010, 1'b0, 64'h0, 8'h0));
    drain("after_timeout", 100);
    chk("after_timeout_err", 64'(lastRespErr), 64'd0);

    // Randomized traffic
    randReady = 1; randTimeouts = 1; gapPct = 30;
    for (int i = 0; i < 80; i++) begin
      guard = 0;
      while (ifuQ.size() + lsuQ.size() >= 4 && guard < 2000) begin @(negedge clk); #1; guard++; end
      if ($urandom_range(1) == 0)
        ifuQ.push_back(mkReq({$urandom, $urandom}, 1'b0, 64'h0, 8'h0));
      else
        lsuQ.push_back(mkReq({$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 8'($urandom)));
      waitCycles($urandom_range(2));
    end
    drain("random", 4000);
    randReady = 0; randTimeouts = 0; gapPct = 0;

    // Reset while waiting for a reply
    forceNoResp = 1;
    hs0 = hsCnt;
    lsuQ.push_back(mkReq(64'h8000_5000, 1'b0, 64'h0, 8'h0));
    guard = 0;
    while (hsCnt == hs0 && guard < 100) begin @(negedge clk); #1; guard++; end
    chk("reset_reached_wait", 64'(hsCnt - hs0), 64'd1);
    waitCycles(3);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    waitCycles(2);
    chk("reset_spurious_clear", 64'(spurious_resp), 64'd0);
    strayReq = 1;
    waitCycles(3);
    chk("late_resp_spurious", 64'(spurious_resp), 64'd1);
    forceNoResp = 0;
    ifuQ.push_back(mkReq(64'h8000_0020, 1'b0, 64'h0, 8'h0));
    drain("after_reset", 100);
    chk("after_reset_err", 64'(lastRespErr), 64'd0);

    chk("accepts_vs_handshakes", 64'(accCnt), 64'(hsCnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
